register_bank: RTL and testbench
================================

Name: register_bank

Overview:
- 32 x 32-bit general-purpose register file for the multicycle MIPS datapath.
- Sits directly downstream of the register-destination mux, which supplies the 5-bit write index (rt, rd, $ra=31, $sp=29 or rs-derived). The write-data mux supplies the write value.
- Provides two read ports feeding the A/B operand latches.
- Owns reset initialisation of $sp, the hardwired-zero rule for $zero, and optional write-to-read bypass.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth is 2**ADDR_W.
- SP_RESET, 227, reset value loaded into register 29 ($sp).
- BYPASS, 1, 1 = a read of the register being written this cycle returns WriteData; 0 = returns the stored (old) value.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- RegWrite  input  1  write enable, from the control unit.
- WriteReg  input  ADDR_W  destination index, from the register-destination mux (low 5 bits of its output).
- WriteData  input  DATA_W  value to write.
- ReadReg1  input  ADDR_W  read index, port 1 (rs).
- ReadReg2  input  ADDR_W  read index, port 2 (rt).
- ReadData1  output  DATA_W  contents at ReadReg1.
- ReadData2  output  DATA_W  contents at ReadReg2.

Behaviour:
- Reset (Already decided): one clock; reset is synchronous and active-low.
  - When reset==0 at a rising clk edge, all registers clear to 0, except register 29, which loads SP_RESET.
  - Reset dominates RegWrite: no write occurs on a reset edge.
  - Reset asserted mid-program discards all prior contents. No partial state survives.
- Write:
  - On a rising edge with reset==1, RegWrite==1 and WriteReg!=0, mem[WriteReg] takes WriteData.
  - Latency: 1 cycle. The new value is visible through the array from the next cycle on.
- $zero:
  - Writes to index 0 are silently dropped.
  - Reads of index 0 always return 0, regardless of BYPASS or any pending write.
- Read (combinational, zero latency):
  - ReadDataN = mem[ReadRegN].
  - If BYPASS==1, RegWrite==1, WriteReg==ReadRegN and ReadRegN!=0, then ReadDataN = WriteData in the same cycle.
  - Both ports are independent; ReadReg1==ReadReg2 returns identical data on both.
- Reset values of outputs:
  - Outputs are combinational and are not registered.
  - After the reset edge, ReadDataN = 0 for every index except 29, which reads SP_RESET.
- Width rules:
  - No sign or zero extension inside the block; data is stored verbatim.
  - Unknown/X on WriteReg with RegWrite==0 has no effect on state.
- Simultaneous events:
  - A write and a read of the same index in one cycle follow the BYPASS rule.
  - After the edge, the stored value equals WriteData in either mode.
- Special destinations:
  - A write to 29 or 31 is an ordinary write; there is no special protection.
  - SP_RESET applies only at reset.

Decomposition:
- Shared package (mips_pkg):
  - DATA_W=32, ADDR_W=5.
  - Register index constants REG_ZERO=0, REG_SP=29, REG_RA=31.
  - SP_RESET default 227.
  - The RegDest select encodings (0=rt, 1=rd, 2=$ra, 3=$sp, 4=rs) for the upstream mux.
- Sub-module: one natural helper, reg_read_port. It implements the zero-check, bypass compare and array read, and is instantiated twice, once per read port.
- The storage array and write logic stay in register_bank.

Test Plan:
1. Reset: hold reset=0 one edge, then read all 32 indices.
   -> every ReadData=0 except index 29 = 227.
2. Basic write: RegWrite=1, WriteReg=8, WriteData=0xDEADBEEF, one edge, then ReadReg1=8.
   -> ReadData1=0xDEADBEEF. Index 9 still reads 0.
3. $zero: RegWrite=1, WriteReg=0, WriteData=0xFFFFFFFF, one edge; ReadReg1=ReadReg2=0.
   -> both read 0, also during the write cycle with BYPASS=1.
4. Bypass: reg 5 holds 0x11; same cycle RegWrite=1, WriteReg=5, WriteData=0x22, ReadReg2=5.
   -> BYPASS=1: ReadData2=0x22 before the edge. BYPASS=0: 0x11 before the edge.
   -> Both modes: 0x22 after the edge.
5. Reset vs write: write 0x1234 to reg 29, then reset=0 with RegWrite=1, WriteReg=29, WriteData=0x5555.
   -> after the edge reg 29 = 227 and no other register is written.
6. Special destinations: write 0x00400010 to 31 and 0x100 to 29 on consecutive edges; read both ports at 31 and 29.
   -> ReadData1=0x00400010, ReadData2=0x100. All other indices are unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS datapath: widths, architectural
// register indices and the register-destination mux select encoding.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

    localparam int SP_RESET = 227;

    // Select encoding for the mux that produces WriteReg upstream of the bank.
    typedef enum logic [2:0] {
        REGDST_RT = 3'd0,
        REGDST_RD = 3'd1,
        REGDST_RA = 3'd2,
        REGDST_SP = 3'd3,
        REGDST_RS = 3'd4
    } regdst_e;

endpackage : mips_pkg

// File: rtl/register_bank_if.sv
// Write port plus two read ports of the register bank; the master is the
// datapath, the slave is the bank.
interface register_bank_if #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
);
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    modport master (
        output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
        output ReadData1, ReadData2
    );
endinterface : register_bank_if

// File: rtl/reg_read_port.sv
// One combinational read port: $zero forcing, optional same-cycle write
// bypass, otherwise a plain array lookup.
module reg_read_port
    import mips_pkg::REG_ZERO;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic [DATA_W-1:0] mem_i [2**ADDR_W],
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o
);

    always_comb begin
        rd_data_o = '0;
        // $zero wins over everything, including a bypassed write.
        if (rd_addr_i != ADDR_W'(REG_ZERO)) begin
            if ((BYPASS != 0) && we_i && (wr_addr_i == rd_addr_i)) begin
                rd_data_o = wr_data_i;
            end else begin
                rd_data_o = mem_i[rd_addr_i];
            end
        end
    end

endmodule : reg_read_port

// File: rtl/register_bank.sv
// 32 x 32 general-purpose register file: one synchronous write port, two
// combinational read ports, $sp preset on the active-low synchronous reset.
module register_bank #(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int ADDR_W   = mips_pkg::ADDR_W,
    parameter int SP_RESET = mips_pkg::SP_RESET,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            reset,
    register_bank_if.slave  bus
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        localparam logic [DATA_W-1:0] RST_VAL =
            (gi == mips_pkg::REG_SP) ? DATA_W'(SP_RESET) : '0;
        // Register 0 still owns a flop so the array is uniform; it is simply never written.
        localparam bit WRITABLE = (gi != mips_pkg::REG_ZERO);

        logic [DATA_W-1:0] val_q;

        always_ff @(posedge clk) begin
            if (!reset) begin
                val_q <= RST_VAL;
            end else if (WRITABLE && bus.RegWrite && (bus.WriteReg == ADDR_W'(gi))) begin
                val_q <= bus.WriteData;
            end
        end

        assign mem_q[gi] = val_q;
    end

    reg_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port1 (
        .mem_i     (mem_q),
        .rd_addr_i (bus.ReadReg1),
        .we_i      (bus.RegWrite),
        .wr_addr_i (bus.WriteReg),
        .wr_data_i (bus.WriteData),
        .rd_data_o (bus.ReadData1)
    );

    reg_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port2 (
        .mem_i     (mem_q),
        .rd_addr_i (bus.ReadReg2),
        .we_i      (bus.RegWrite),
        .wr_addr_i (bus.WriteReg),
        .wr_data_i (bus.WriteData),
        .rd_data_o (bus.ReadData2)
    );

endmodule : register_bank

// File: tb/tb_register_bank.sv
// Drives a bypassing and a non-bypassing register bank with identical stimulus
// and compares both against an array-based reference of the register file rules.
module tb_register_bank;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    register_bank_if #(.DATA_W(32), .ADDR_W(5)) if_b ();
    register_bank_if #(.DATA_W(32), .ADDR_W(5)) if_n ();

    register_bank #(.DATA_W(32), .ADDR_W(5), .SP_RESET(227), .BYPASS(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    register_bank #(.DATA_W(32), .ADDR_W(5), .SP_RESET(227), .BYPASS(0)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (if_n)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] model [32];

    logic        cur_we;
    logic [4:0]  cur_wreg;
    logic [31:0] cur_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit byp);
        if (addr == 5'd0) return 32'h0;
        if (byp && cur_we) begin
            if (cur_wreg == addr) return cur_wdata;
        end
        return model[addr];
    endfunction

    task automatic drive(input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                         input logic [4:0] r1, input logic [4:0] r2);
        cur_we = we; cur_wreg = wreg; cur_wdata = wdata;
        if_b.RegWrite = we; if_b.WriteReg = wreg; if_b.WriteData = wdata;
        if_n.RegWrite = we; if_n.WriteReg = wreg; if_n.WriteData = wdata;
        if_b.ReadReg1 = r1; if_b.ReadReg2 = r2;
        if_n.ReadReg1 = r1; if_n.ReadReg2 = r2;
    endtask

    // Advance one rising edge, apply the register-file rules to the model, return at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 32; i++) model[i] = (i == 29) ? 32'd227 : 32'd0;
        end else if (cur_we === 1'b1 && cur_wreg != 5'd0) begin
            model[cur_wreg] = cur_wdata;
        end
        @(negedge clk);
    endtask

    task automatic check_ports(input string tag);
        #1;
        check($sformatf("%s byp rd1[%0d]", tag, if_b.ReadReg1), if_b.ReadData1, exp_read(if_b.ReadReg1, 1'b1));
        check($sformatf("%s byp rd2[%0d]", tag, if_b.ReadReg2), if_b.ReadData2, exp_read(if_b.ReadReg2, 1'b1));
        check($sformatf("%s nob rd1[%0d]", tag, if_n.ReadReg1), if_n.ReadData1, exp_read(if_n.ReadReg1, 1'b0));
        check($sformatf("%s nob rd2[%0d]", tag, if_n.ReadReg2), if_n.ReadData2, exp_read(if_n.ReadReg2, 1'b0));
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            check_ports(tag);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'hxxxx_xxxx;
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        tick();
        reset = 1'b1;

        // Reset values
        sweep("reset");
        drive(1'b0, 5'd0, 32'h0, 5'd29, 5'd28);
        #1;
        check("reset sp", if_b.ReadData1, 32'd227);
        check("reset r28", if_n.ReadData2, 32'd0);

        // Basic write
        drive(1'b1, 5'd8, 32'hDEADBEEF, 5'd1, 5'd2);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd9);
        check_ports("write8");
        check("write8 direct", if_n.ReadData1, 32'hDEADBEEF);
        check("write8 r9", if_n.ReadData2, 32'h0);

        // $zero, during and after the write cycle
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        #1;
        check("zero byp during rd1", if_b.ReadData1, 32'h0);
        check("zero byp during rd2", if_b.ReadData2, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        check_ports("zero after");

        // Bypass vs stored value
        drive(1'b1, 5'd5, 32'h11, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd5, 32'h22, 5'd5, 5'd5);
        check_ports("bypass during");
        check("bypass byp rd2", if_b.ReadData2, 32'h22);
        check("bypass nob rd2", if_n.ReadData2, 32'h11);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
        #1;
        check("bypass after byp", if_b.ReadData2, 32'h22);
        check("bypass after nob", if_n.ReadData2, 32'h22);

        // Reset dominates a simultaneous write
        drive(1'b1, 5'd29, 32'h1234, 5'd0, 5'd0);
        tick();
        reset = 1'b0;
        drive(1'b1, 5'd29, 32'h5555, 5'd0, 5'd0);
        tick();
        reset = 1'b1;
        sweep("reset vs write");
        drive(1'b0, 5'd0, 32'h0, 5'd29, 5'd8);
        #1;
        check("rst-vs-wr sp", if_n.ReadData1, 32'd227);
        check("rst-vs-wr r8 cleared", if_b.ReadData2, 32'd0);

        // Special destinations
        drive(1'b1, 5'd31, 32'h00400010, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd29, 32'h100, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd29);
        check_ports("special");
        check("special ra", if_b.ReadData1, 32'h00400010);
        check("special sp", if_n.ReadData2, 32'h100);
        sweep("special sweep");

        // Unknown WriteReg with RegWrite low must not disturb state
        drive(1'b0, 5'bxxxxx, 32'hCAFEF00D, 5'd31, 5'd29);
        check_ports("xaddr during");
        tick();
        sweep("xaddr after");

        // Randomized traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) begin
                if_b.ReadReg2 = cur_wreg; if_n.ReadReg2 = cur_wreg;
            end
            check_ports($sformatf("rand%0d", n));
            tick();
        end
        reset = 1'b1;
        sweep("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_register_bank
